block_sync: RTL and testbench

//   Rx 64b/66b-style block synchroniser that sits directly upstream of the descrambler.
//   - Takes 64-bit raw words from the deserialiser and finds the 64-bit frame boundary:
//     2-bit sync header followed by a 62-bit scrambled payload.
//   - Acquires and holds block lock with a slip-based hunt state machine.
//   - Drives scrambled_data_out / data_valid_out straight into the descrambler
//     (scrambled_data_in / descrambler_en).

---
 rtl/serdes_pcs_pkg.sv | 17 +
 rtl/block_sync_shifter.sv | 24 ++
 rtl/block_sync.sv | 164 ++++++++++++++++
 tb/tb_block_sync.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pcs_pkg.sv
// Shared PCS definitions: block-sync FSM states, sync header codes and the
// lock/unlock thresholds also used by the Tx side.
package serdes_pcs_pkg;

  typedef enum logic [1:0] {HUNT, SLIP_WAIT, LOCKED} blk_sync_state_t;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int LOCK_CNT_DEF   = 64;
  localparam int UNLOCK_INV_DEF = 16;

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_shifter.sv
// Combinational 128->64 barrel select: window = cat[offset +: WORD_WIDTH],
// with bit 0 being the earliest received bit.
module block_sync_shifter #(
  parameter int WORD_WIDTH = 64
) (
  input  logic [0:2*WORD_WIDTH-1]        cat_i,
  input  logic [$clog2(WORD_WIDTH)-1:0]  offset_i,
  output logic [0:WORD_WIDTH-1]          window_o
);

  localparam int IW = $clog2(2*WORD_WIDTH);

  logic [IW-1:0] idx;

  always_comb begin
    window_o = '0;
    idx      = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      idx         = IW'(offset_i) + IW'(i);
      window_o[i] = cat_i[idx];
    end
  end

endmodule

// File: rtl/block_sync.sv
// 64b/66b-style Rx block synchroniser: slip-based hunt for the sync header,
// lock/unlock hysteresis, and registered aligned payload for the descrambler.
module block_sync
  import serdes_pcs_pkg::*;
#(
  parameter int DATA_WIDTH    = 62,
  parameter int WORD_WIDTH    = 64,
  parameter int LOCK_CNT      = LOCK_CNT_DEF,
  parameter int UNLOCK_INV    = UNLOCK_INV_DEF,
  parameter int SLIP_WAIT_CYC = 2
) (
  input  logic                           clk_390p625M,
  input  logic                           rst,
  input  logic [0:WORD_WIDTH-1]          raw_data_in,
  input  logic                           raw_valid_in,
  output logic [0:DATA_WIDTH-1]          scrambled_data_out,
  output logic [1:0]                     sync_header_out,
  output logic                           data_valid_out,
  output logic                           header_err_out,
  output logic                           block_lock_out,
  output logic [$clog2(WORD_WIDTH)-1:0]  slip_offset_out
);

  localparam int OFF_W  = $clog2(WORD_WIDTH);
  localparam int WAIT_W = (SLIP_WAIT_CYC > 1) ? $clog2(SLIP_WAIT_CYC) : 1;

  blk_sync_state_t       state_q, state_d;
  logic [0:WORD_WIDTH-1] word_d1_q, word_d1_d;
  logic [OFF_W-1:0]      offset_q, offset_d;
  logic [6:0]            sh_cnt_q, sh_cnt_d;
  logic [4:0]            sh_inv_cnt_q, sh_inv_cnt_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  lock_q, lock_d;
  logic [0:DATA_WIDTH-1] data_q, data_d;
  logic [1:0]            sh_q, sh_d;
  logic                  err_q, err_d;
  logic                  dv_q, dv_d;

  logic [0:2*WORD_WIDTH-1] cat;
  logic [0:WORD_WIDTH-1]   window;
  logic [1:0]              sh;
  logic                    hv;
  logic                    slip;
  logic [6:0]              cnt_nx;
  logic [4:0]              inv_nx;

  assign cat = {word_d1_q, raw_data_in};

  block_sync_shifter #(.WORD_WIDTH(WORD_WIDTH)) u_shifter (
    .cat_i    (cat),
    .offset_i (offset_q),
    .window_o (window)
  );

  assign sh = {window[0], window[1]};
  assign hv = sh_valid(sh);

  always_comb begin
    state_d      = state_q;
    word_d1_d    = word_d1_q;
    offset_d     = offset_q;
    sh_cnt_d     = sh_cnt_q;
    sh_inv_cnt_d = sh_inv_cnt_q;
    wait_d       = wait_q;
    lock_d       = lock_q;
    data_d       = data_q;
    sh_d         = sh_q;
    err_d        = err_q;
    dv_d         = 1'b0;
    slip         = 1'b0;
    cnt_nx       = sh_cnt_q + 7'd1;
    inv_nx       = sh_inv_cnt_q + (hv ? 5'd0 : 5'd1);

    if (raw_valid_in) begin
      word_d1_d = raw_data_in;
      data_d    = window[2 +: DATA_WIDTH];
      sh_d      = sh;
      err_d     = !hv;

      unique case (state_q)
        HUNT: begin
          if (!hv) begin
            slip = 1'b1;
          end else if (cnt_nx == 7'(LOCK_CNT)) begin
            state_d  = LOCKED;
            lock_d   = 1'b1;
            sh_cnt_d = '0;
          end else begin
            sh_cnt_d = cnt_nx;
          end
        end
        SLIP_WAIT: begin
          // Let the two-word window refill at the new offset before trusting headers.
          if (wait_q == WAIT_W'(SLIP_WAIT_CYC - 1)) begin
            state_d = HUNT;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        LOCKED: begin
          // Unlock is checked first so a 16th bad header on the 64th word wins.
          if (inv_nx == 5'(UNLOCK_INV)) begin
            slip   = 1'b1;
            lock_d = 1'b0;
          end else if (cnt_nx == 7'(LOCK_CNT)) begin
            sh_cnt_d     = '0;
            sh_inv_cnt_d = '0;
          end else begin
            sh_cnt_d     = cnt_nx;
            sh_inv_cnt_d = inv_nx;
          end
        end
        default: state_d = HUNT;
      endcase

      if (slip) begin
        offset_d     = offset_q + OFF_W'(1);
        sh_cnt_d     = '0;
        sh_inv_cnt_d = '0;
        wait_d       = '0;
        state_d      = SLIP_WAIT;
      end

      dv_d = lock_d;
    end
  end

  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      state_q      <= HUNT;
      word_d1_q    <= '0;
      offset_q     <= '0;
      sh_cnt_q     <= '0;
      sh_inv_cnt_q <= '0;
      wait_q       <= '0;
      lock_q       <= 1'b0;
      data_q       <= '0;
      sh_q         <= '0;
      err_q        <= 1'b0;
      dv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_d1_q    <= word_d1_d;
      offset_q     <= offset_d;
      sh_cnt_q     <= sh_cnt_d;
      sh_inv_cnt_q <= sh_inv_cnt_d;
      wait_q       <= wait_d;
      lock_q       <= lock_d;
      data_q       <= data_d;
      sh_q         <= sh_d;
      err_q        <= err_d;
      dv_q         <= dv_d;
    end
  end

  assign scrambled_data_out = data_q;
  assign sync_header_out    = sh_q;
  assign data_valid_out     = dv_q;
  assign header_err_out     = err_q;
  assign block_lock_out     = lock_q;
  assign slip_offset_out    = offset_q;

endmodule

// File: tb/tb_block_sync.sv
// Directed bench for block_sync. Training stream alternates DATA(01+ones) and
// CTRL(10+zeros) blocks, so only the true boundary ever yields a valid header.
module tb_block_sync;
  import serdes_pcs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:63] raw_data_in;
  logic        raw_valid_in;
  logic [0:61] scrambled_data_out;
  logic [1:0]  sync_header_out;
  logic        data_valid_out;
  logic        header_err_out;
  logic        block_lock_out;
  logic [5:0]  slip_offset_out;

  int errs   = 0;
  int checks = 0;

  logic [0:63] prev_blk;
  int          shift_s;
  bit          train_ctrl;
  logic [0:61] exp_pl;
  logic [1:0]  exp_sh;

  always #5 clk = ~clk;

  block_sync dut (
    .clk_390p625M       (clk),
    .rst                (rst),
    .raw_data_in        (raw_data_in),
    .raw_valid_in       (raw_valid_in),
    .scrambled_data_out (scrambled_data_out),
    .sync_header_out    (sync_header_out),
    .data_valid_out     (data_valid_out),
    .header_err_out     (header_err_out),
    .block_lock_out     (block_lock_out),
    .slip_offset_out    (slip_offset_out)
  );

  function automatic logic [0:63] rnd_blk(input logic [1:0] h);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {h, r[61:0]};
  endfunction

  // Serialise blocks with a shift_s-bit lead; the DUT's window at the right
  // offset shows the block sent one word earlier.
  task automatic send(input logic [0:63] blk);
    logic [0:127] c;
    c            = {prev_blk, blk};
    raw_data_in  = c[64-shift_s +: 64];
    raw_valid_in = 1'b1;
    exp_pl       = prev_blk[2:63];
    exp_sh       = {prev_blk[0], prev_blk[1]};
    prev_blk     = blk;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    raw_valid_in = 1'b0;
    raw_data_in  = {$urandom, $urandom};
    @(posedge clk); #1;
  endtask

  task automatic next_train(output logic [0:63] b);
    b          = train_ctrl ? {SH_CTRL, 62'h0} : {SH_DATA, {62{1'b1}}};
    train_ctrl = !train_ctrl;
  endtask

  task automatic start_stream(input int s);
    shift_s    = s;
    prev_blk   = {$urandom, $urandom};
    train_ctrl = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    raw_valid_in = 1'b0;
    raw_data_in  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Zeroed history forces a slip on word 0; offset s is then hunted from word 3s.
  task automatic acquire(input int s);
    logic [0:63] b;
    do_reset();
    start_stream(s);
    for (int n = 0; n <= 3*s + 63; n++) begin
      next_train(b);
      send(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; raw_valid_in = 1'b0; raw_data_in = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (scrambled_data_out !== 62'h0) $display("FAIL reset_data got=%h want=0", scrambled_data_out);
    else checks += 0;
    if (scrambled_data_out !== 62'h0) errs++;
    checks++; if (sync_header_out !== 2'b00) begin errs++; $display("FAIL reset_sh got=%b want=00", sync_header_out); end
    checks++; if (data_valid_out !== 1'b0) begin errs++; $display("FAIL reset_dv got=%b want=0", data_valid_out); end
    checks++; if (header_err_out !== 1'b0) begin errs++; $display("FAIL reset_err got=%b want=0", header_err_out); end
    checks++; if (block_lock_out !== 1'b0) begin errs++; $display("FAIL reset_lock got=%b want=0", block_lock_out); end
    checks++; if (slip_offset_out !== 6'd0) begin errs++; $display("FAIL reset_off got=%0d want=0", slip_offset_out); end
  endtask

  // Offset 0 is only reached by slipping through all 63 others and wrapping 63->0.
  task automatic test_aligned();
    logic [0:63] b;
    int j;
    do_reset();
    start_stream(0);
    for (int n = 0; n <= 255; n++) begin
      next_train(b);
      send(b);
      j = n/3 + 1;
      if (j > 64) j = 64;
      checks++; if (slip_offset_out !== 6'(j % 64)) begin errs++; $display("FAIL aligned_off word=%0d got=%0d want=%0d", n, slip_offset_out, j % 64); end
      checks++; if (block_lock_out !== (n == 255)) begin errs++; $display("FAIL aligned_lock word=%0d got=%b want=%b", n, block_lock_out, n == 255); end
      checks++; if (data_valid_out !== (n == 255)) begin errs++; $display("FAIL aligned_dv word=%0d got=%b want=%b", n, data_valid_out, n == 255); end
    end
    for (int n = 0; n < 20; n++) begin
      send(rnd_blk(n[0] ? SH_CTRL : SH_DATA));
      checks++; if (scrambled_data_out !== exp_pl) begin errs++; $display("FAIL aligned_payload k=%0d got=%h want=%h", n, scrambled_data_out, exp_pl); end
      checks++; if (sync_header_out !== exp_sh) begin errs++; $display("FAIL aligned_sh k=%0d got=%b want=%b", n, sync_header_out, exp_sh); end
      checks++; if (data_valid_out !== 1'b1 || header_err_out !== 1'b0) begin errs++; $display("FAIL aligned_stream k=%0d dv=%b err=%b want dv=1 err=0", n, data_valid_out, header_err_out); end
    end
  endtask

  task automatic test_shift17();
    logic [0:63] b;
    int j;
    do_reset();
    start_stream(17);
    for (int n = 0; n <= 114; n++) begin
      next_train(b);
      send(b);
      j = n/3 + 1;
      if (j > 17) j = 17;
      checks++; if (slip_offset_out !== 6'(j)) begin errs++; $display("FAIL shift17_off word=%0d got=%0d want=%0d", n, slip_offset_out, j); end
      checks++; if (block_lock_out !== (n == 114)) begin errs++; $display("FAIL shift17_lock word=%0d got=%b want=%b", n, block_lock_out, n == 114); end
    end
    send(rnd_blk(SH_DATA));
    checks++; if (scrambled_data_out !== exp_pl) begin errs++; $display("FAIL shift17_payload got=%h want=%h", scrambled_data_out, exp_pl); end
  endtask

  task automatic test_bad_headers();
    int pulses;
    acquire(1);
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      send(i < 15 ? rnd_blk(i[0] ? 2'b11 : 2'b00) : rnd_blk(SH_DATA));
      if (header_err_out === 1'b1) pulses++;
      checks++; if (block_lock_out !== 1'b1) begin errs++; $display("FAIL bad15_lock i=%0d got=%b want=1", i, block_lock_out); end
    end
    checks++; if (pulses != 15) begin errs++; $display("FAIL bad15_pulses got=%0d want=15", pulses); end
    for (int i = 0; i <= 16; i++) begin
      send(i < 16 ? rnd_blk(i[0] ? 2'b00 : 2'b11) : rnd_blk(SH_DATA));
      checks++; if (block_lock_out !== (i < 16)) begin errs++; $display("FAIL bad16_lock i=%0d got=%b want=%b", i, block_lock_out, i < 16); end
      checks++; if (header_err_out !== (i > 0)) begin errs++; $display("FAIL bad16_err i=%0d got=%b want=%b", i, header_err_out, i > 0); end
      checks++; if (scrambled_data_out !== exp_pl) begin errs++; $display("FAIL bad16_payload i=%0d got=%h want=%h", i, scrambled_data_out, exp_pl); end
    end
    checks++; if (slip_offset_out !== 6'd2) begin errs++; $display("FAIL bad16_off got=%0d want=2", slip_offset_out); end
    checks++; if (data_valid_out !== 1'b0) begin errs++; $display("FAIL bad16_dv got=%b want=0", data_valid_out); end
  endtask

  // 16 bad headers at valid words 24..39 unlock only if idle cycles do not count.
  task automatic test_valid_toggle();
    acquire(1);
    for (int v = 0; v < 40; v++) begin
      send((v >= 23 && v <= 38) ? rnd_blk(2'b11) : rnd_blk(SH_CTRL));
      checks++; if (data_valid_out !== (v < 39)) begin errs++; $display("FAIL toggle_dv_valid v=%0d got=%b want=%b", v, data_valid_out, v < 39); end
      checks++; if (block_lock_out !== (v < 39)) begin errs++; $display("FAIL toggle_lock v=%0d got=%b want=%b", v, block_lock_out, v < 39); end
      idle();
      checks++; if (data_valid_out !== 1'b0) begin errs++; $display("FAIL toggle_dv_idle v=%0d got=%b want=0", v, data_valid_out); end
      checks++; if (scrambled_data_out !== exp_pl) begin errs++; $display("FAIL toggle_hold v=%0d got=%h want=%h", v, scrambled_data_out, exp_pl); end
    end
    checks++; if (slip_offset_out !== 6'd2) begin errs++; $display("FAIL toggle_off got=%0d want=2", slip_offset_out); end
  endtask

  task automatic test_reset_locked();
    logic [0:63] b;
    acquire(1);
    checks++; if (block_lock_out !== 1'b1) begin errs++; $display("FAIL rstlk_pre got=%b want=1", block_lock_out); end
    rst = 1'b1;
    next_train(b);
    send(b);
    rst = 1'b0;
    checks++; if (block_lock_out !== 1'b0 || data_valid_out !== 1'b0) begin errs++; $display("FAIL rstlk_lock lock=%b dv=%b want 0 0", block_lock_out, data_valid_out); end
    checks++; if (slip_offset_out !== 6'd0) begin errs++; $display("FAIL rstlk_off got=%0d want=0", slip_offset_out); end
    checks++; if (scrambled_data_out !== 62'h0 || sync_header_out !== 2'b00 || header_err_out !== 1'b0) begin
      errs++; $display("FAIL rstlk_out data=%h sh=%b err=%b want all 0", scrambled_data_out, sync_header_out, header_err_out);
    end
    for (int n = 0; n <= 66; n++) begin
      next_train(b);
      send(b);
      checks++; if (block_lock_out !== (n == 66)) begin errs++; $display("FAIL rstlk_relock word=%0d got=%b want=%b", n, block_lock_out, n == 66); end
    end
    checks++; if (slip_offset_out !== 6'd1) begin errs++; $display("FAIL rstlk_reloff got=%0d want=1", slip_offset_out); end
  endtask

  initial begin
    rst = 1'b1; raw_valid_in = 1'b0; raw_data_in = '0;
    shift_s = 0; prev_blk = '0; train_ctrl = 1'b0; exp_pl = '0; exp_sh = '0;
    test_reset();
    test_aligned();
    test_shift17();
    test_bad_headers();
    test_valid_toggle();
    test_reset_locked();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
